// File: rtl/fifo_rd_drain_pkg.sv
// Shared definitions for the FIFO read-drain controller: FSM state
// encoding and default parameter values.
package fifo_rd_drain_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_CMPL  = 2'd3
    } state_t;

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry in-order output buffer between the FIFO read port and the
// downstream valid/ready stream. Entry q0 is always the head and drives dout.
// push must only be asserted when (count - pop) < 2.
module drain_skid_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] q0;
    logic [DATA_W-1:0] q1;
    logic              load_q0_from_q1;
    logic              load_q0_from_din;
    logic              load_q1;

    // The head advances from q1 on a pop with two entries; a push lands in the
    // head when the buffer is (or is becoming) empty, otherwise in q1.
    always_comb begin
        load_q0_from_q1  = pop && (count == 2'd2);
        load_q0_from_din = push && ((count == 2'd0) || ((count == 2'd1) && pop));
        load_q1          = push && (((count == 2'd1) && !pop) || ((count == 2'd2) && pop));
    end

    // Occupancy tracks pushes and pops; a reset discards anything buffered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 2'd0;
        end else begin
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // Head entry is cleared on reset so the stream data reads zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q0 <= '0;
        end else if (load_q0_from_q1) begin
            q0 <= q1;
        end else if (load_q0_from_din) begin
            q0 <= din;
        end
    end

    // Second entry only ever holds data behind a valid head, so it needs no reset.
    always_ff @(posedge clk) begin
        if (load_q1) begin
            q1 <= din;
        end
    end

    assign dout = q0;

endmodule

// File: rtl/fifo_rd_drain.sv
// Read-side drain controller for an asymmetric 4-to-32 FIFO. Reads complete
// words into a two-entry output buffer, and on a flush request drains the
// zero-padded partial words the FIFO presents until it reports flush done.
// Optional feature macro: FIFO_RD_DRAIN_AUTO_FLUSH_EN enables an automatic
// flush after TIMEOUT idle cycles with only partial data in the FIFO.
module fifo_rd_drain
    import fifo_rd_drain_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_vld_rd_data,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_flush_done,
    output logic              fifo_rd,
    output logic              fifo_flush_req,
    input  logic              flush_cmd,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              flush_cmpl,
    output logic              busy
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("fifo_rd_drain: TIMEOUT must lie in 2..255");
    end

    state_t     state;
    state_t     state_nxt;
    logic [1:0] count;
    logic       pop;
    logic       space;
    logic       flush_trig;
    logic       flush_req_q;

    // A pop frees an entry in the same cycle, so a full buffer can still accept.
    assign pop   = m_valid & m_ready;
    assign space = (count != 2'd2) | pop;

`ifdef FIFO_RD_DRAIN_AUTO_FLUSH_EN
    logic [7:0] idle_cnt;
    logic       timeout_hit;

    // Count idle cycles during which the FIFO holds only a partial word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= 8'd0;
        end else if ((state == ST_IDLE) && !fifo_empty && !fifo_vld_rd_data) begin
            idle_cnt <= idle_cnt + 8'd1;
        end else begin
            idle_cnt <= 8'd0;
        end
    end

    assign timeout_hit = (idle_cnt == 8'(TIMEOUT - 1));
    assign flush_trig  = flush_cmd | timeout_hit;
`else
    assign flush_trig = flush_cmd;
`endif

    // State register; a reset abandons any flush in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode. Flush triggers with nothing in the FIFO, or while a
    // flush is already under way, are dropped rather than remembered.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (flush_trig && !fifo_empty) begin
                    state_nxt = ST_FLUSH;
                end else if (fifo_vld_rd_data) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush_trig && !fifo_empty) begin
                    state_nxt = ST_FLUSH;
                end else if (!fifo_vld_rd_data && (count == 2'd0)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (fifo_flush_done) begin
                    state_nxt = ST_CMPL;
                end
            end
            ST_CMPL: begin
                if (count == 2'd0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode: read strobe, completion pulse and busy indication.
    always_comb begin
        fifo_rd    = 1'b0;
        flush_cmpl = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_RUN:   fifo_rd    = space & fifo_vld_rd_data;
            ST_FLUSH: fifo_rd    = space & !fifo_empty;
            ST_CMPL:  flush_cmpl = (count == 2'd0);
            default:  ;
        endcase
    end

    // Flush request is registered off the next state so it rises on entry to
    // FLUSH and drops on the same edge that moves to CMPL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flush_req_q <= 1'b0;
        end else begin
            flush_req_q <= (state_nxt == ST_FLUSH);
        end
    end

    assign fifo_flush_req = flush_req_q;

    drain_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_rd),
        .din   (fifo_rd_data),
        .pop   (pop),
        .dout  (m_data),
        .count (count)
    );

    assign m_valid = (count != 2'd0);

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed bench for fifo_rd_drain with a behavioural 4-to-32 FIFO model.
// Nibbles are packed LSB-first; a flush presents the nibbles held when the
// flush request rose, zero-padded, and reports done a few cycles after the
// last of them is read.
module tb_fifo_rd_drain;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fifo_vld_rd_data = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_rd_data = 32'd0;
    logic        fifo_flush_done = 1'b0;
    logic        fifo_rd;
    logic        fifo_flush_req;
    logic        flush_cmd = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic        flush_cmpl;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fifo_rd_drain #(
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fifo_vld_rd_data (fifo_vld_rd_data),
        .fifo_empty       (fifo_empty),
        .fifo_rd_data     (fifo_rd_data),
        .fifo_flush_done  (fifo_flush_done),
        .fifo_rd          (fifo_rd),
        .fifo_flush_req   (fifo_flush_req),
        .flush_cmd        (flush_cmd),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_data           (m_data),
        .flush_cmpl       (flush_cmpl),
        .busy             (busy)
    );

    // ---------------- FIFO model ----------------
    logic [3:0] wr_nib[$];   // appended by stimulus only
    int         wr_idx = 0;  // consumed by the model only
    logic [3:0] nq[$];
    bit         in_flush = 1'b0;
    int         flush_rem = 0;
    int         done_dly = 0;

    function automatic logic [31:0] head_word(input int n);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 8; i++)
            if (i < n && i < nq.size()) w[4*i +: 4] = nq[i];
        return w;
    endfunction

    always @(posedge clk) begin
        bit rd_s;
        int k;
        rd_s = fifo_rd;
        #1;
        if (!rst) begin
            nq.delete();
            in_flush  = 1'b0;
            flush_rem = 0;
            done_dly  = 0;
            wr_idx    = wr_nib.size();
        end else begin
            if (rd_s) begin
                k = in_flush ? ((flush_rem < 8) ? flush_rem : 8) : 8;
                for (int i = 0; i < k; i++) void'(nq.pop_front());
                if (in_flush) flush_rem -= k;
            end
            if (fifo_flush_req && !in_flush) begin
                in_flush  = 1'b1;
                flush_rem = nq.size();
                done_dly  = 0;
            end else if (!fifo_flush_req && in_flush) begin
                in_flush = 1'b0;
            end
            if (in_flush && flush_rem == 0) done_dly++;
            while (wr_idx < wr_nib.size()) begin
                nq.push_back(wr_nib[wr_idx]);
                wr_idx++;
            end
        end
        fifo_empty       = in_flush ? (flush_rem == 0) : (nq.size() == 0);
        fifo_vld_rd_data = !in_flush && (nq.size() >= 8);
        fifo_rd_data     = in_flush ? head_word((flush_rem < 8) ? flush_rem : 8) : head_word(8);
        fifo_flush_done  = in_flush && (flush_rem == 0) && (done_dly >= 3);
    end

    // ---------------- monitor ----------------
    int          rd_cnt = 0;
    int          cmpl_cnt = 0;
    int          cyc = 0;
    int          cmpl_cyc = 0;
    logic [31:0] rx[$];
    int          rx_cyc[$];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            if (fifo_rd) rd_cnt++;
            if (flush_cmpl) begin
                cmpl_cnt++;
                cmpl_cyc = cyc;
            end
            if (m_valid && m_ready) begin
                rx.push_back(m_data);
                rx_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic write_word(input logic [31:0] w);
        for (int i = 0; i < 8; i++) wr_nib.push_back(w[4*i +: 4]);
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush_cmd = 1'b1;
        @(negedge clk);
        flush_cmd = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n;
        n = 0;
        while (!fifo_flush_req && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, {31'd0, fifo_flush_req}, 32'd1);
    endtask

    task automatic wait_rx(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (rx.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, rx.size(), target);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rd0;
        int rx0;
        int c0;
        int n;

        // reset state
        repeat (3) @(negedge clk);
        check_val("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        check_val("rst_flush_req", {31'd0, fifo_flush_req}, 32'd0);
        check_val("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check_val("rst_flush_cmpl", {31'd0, flush_cmpl}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_m_data", m_data, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // flush_cmd with an empty FIFO is ignored
        pulse_flush();
        check_val("empty_flush_busy", {31'd0, busy}, 32'd0);
        check_val("empty_flush_req", {31'd0, fifo_flush_req}, 32'd0);

        // eight nibbles 1..8 -> one word 0x87654321
        rd0 = rd_cnt;
        rx0 = rx.size();
        for (int i = 1; i <= 8; i++) wr_nib.push_back(4'(i));
        n = 0;
        @(negedge clk);
        while (!fifo_rd && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_val("w1_rd_seen", {31'd0, fifo_rd}, 32'd1);
        @(negedge clk);
        check_val("w1_m_valid", {31'd0, m_valid}, 32'd1);
        check_val("w1_m_data", m_data, 32'h87654321);
        wait_idle("w1_idle", 20);
        check_val("w1_rd_count", rd_cnt - rd0, 1);
        check_val("w1_rx_count", rx.size() - rx0, 1);

        // three words with downstream stalled: only two reads fit
        rd0 = rd_cnt;
        rx0 = rx.size();
        m_ready = 1'b0;
        write_word(32'h76543210);
        write_word(32'hFEDCBA98);
        write_word(32'h0F0F0F0F);
        repeat (8) @(negedge clk);
        check_val("bp_rd_count", rd_cnt - rd0, 2);
        check_val("bp_m_valid", {31'd0, m_valid}, 32'd1);
        check_val("bp_m_data", m_data, 32'h76543210);
        repeat (2) @(negedge clk);
        check_val("bp_m_data_held", m_data, 32'h76543210);
        check_val("bp_rd_count_held", rd_cnt - rd0, 2);
        m_ready = 1'b1;
        wait_rx("bp_rx", rx0 + 3, 20);
        wait_idle("bp_idle", 20);
        check_val("bp_word0", rx[rx0], 32'h76543210);
        check_val("bp_word1", rx[rx0 + 1], 32'hFEDCBA98);
        check_val("bp_word2", rx[rx0 + 2], 32'h0F0F0F0F);
        check_val("bp_rd_total", rd_cnt - rd0, 3);

        // partial word A,B flushed by command
        rx0 = rx.size();
        c0  = cmpl_cnt;
        wr_nib.push_back(4'hA);
        wr_nib.push_back(4'hB);
        repeat (2) @(negedge clk);
        check_val("ab_idle_before", {31'd0, busy}, 32'd0);
        pulse_flush();
        wait_req("ab_req_rise", 5);
        n = 0;
        while (!fifo_flush_done && n < 20) begin
            check_val("ab_req_held", {31'd0, fifo_flush_req}, 32'd1);
            @(negedge clk);
            n++;
        end
        check_val("ab_done_seen", {31'd0, fifo_flush_done}, 32'd1);
        check_val("ab_req_at_done", {31'd0, fifo_flush_req}, 32'd1);
        @(negedge clk);
        check_val("ab_req_drop", {31'd0, fifo_flush_req}, 32'd0);
        check_val("ab_cmpl_pulse", {31'd0, flush_cmpl}, 32'd1);
        @(negedge clk);
        check_val("ab_cmpl_once", {31'd0, flush_cmpl}, 32'd0);
        check_val("ab_busy_low", {31'd0, busy}, 32'd0);
        check_val("ab_rx_count", rx.size() - rx0, 1);
        check_val("ab_word", rx[rx0], 32'h000000BA);
        check_val("ab_cmpl_count", cmpl_cnt - c0, 1);

        // new nibbles during a flush stay out of it; flush_cmd in FLUSH ignored
        rx0 = rx.size();
        c0  = cmpl_cnt;
        wr_nib.push_back(4'hC);
        wr_nib.push_back(4'hD);
        wr_nib.push_back(4'hE);
        repeat (2) @(negedge clk);
        pulse_flush();
        wait_req("mid_req_rise", 5);
        for (int i = 1; i <= 8; i++) wr_nib.push_back(4'(i));
        pulse_flush();
        wait_rx("mid_rx", rx0 + 2, 40);
        wait_idle("mid_idle", 20);
        check_val("mid_flush_word", rx[rx0], 32'h00000EDC);
        check_val("mid_late_word", rx[rx0 + 1], 32'h87654321);
        check_val("mid_late_after_cmpl", {31'd0, rx_cyc[rx0 + 1] > cmpl_cyc}, 32'd1);
        check_val("mid_cmpl_count", cmpl_cnt - c0, 1);

        // single nibble stalled: automatic flush only when the feature is built in
        rx0 = rx.size();
        wr_nib.push_back(4'h5);
        repeat (16) @(negedge clk);
        check_val("to_req_before", {31'd0, fifo_flush_req}, 32'd0);
        @(negedge clk);
`ifdef FIFO_RD_DRAIN_AUTO_FLUSH_EN
        check_val("to_auto_req", {31'd0, fifo_flush_req}, 32'd1);
`else
        check_val("to_no_auto_req", {31'd0, fifo_flush_req}, 32'd0);
        check_val("to_no_auto_busy", {31'd0, busy}, 32'd0);
        pulse_flush();
        wait_req("to_cmd_req", 5);
`endif
        wait_idle("to_idle", 30);
        check_val("to_word", rx[rx0], 32'h00000005);

        // reset in the middle of a flush
        rx0 = rx.size();
        c0  = cmpl_cnt;
        m_ready = 1'b0;
        wr_nib.push_back(4'h9);
        repeat (2) @(negedge clk);
        pulse_flush();
        wait_req("rf_req_rise", 5);
        repeat (2) @(negedge clk);
        check_val("rf_buffered", {31'd0, m_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_val("rf_req_async", {31'd0, fifo_flush_req}, 32'd0);
        check_val("rf_m_valid_async", {31'd0, m_valid}, 32'd0);
        check_val("rf_m_data_async", m_data, 32'd0);
        check_val("rf_busy_async", {31'd0, busy}, 32'd0);
        check_val("rf_rd_async", {31'd0, fifo_rd}, 32'd0);
        check_val("rf_cmpl_async", {31'd0, flush_cmpl}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_ready = 1'b1;
        repeat (10) @(negedge clk);
        check_val("rf_no_cmpl", cmpl_cnt - c0, 0);
        check_val("rf_busy_after", {31'd0, busy}, 32'd0);
        check_val("rf_no_rx", rx.size() - rx0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_rd_drain.md
FIFO_RD_DRAIN -- requirements
Module: fifo_rd_drain

Interface
REQ-001 Parameter DATA_W, default 32, read-word width of the upstream asymmetric 4-to-32 FIFO.
REQ-002 Parameter TIMEOUT, default 16, idle cycles with partial data before an automatic flush (range 2..255).
REQ-003 clk  in  1  clock; all flops positive-edge triggered.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 fifo_vld_rd_data  in  1  FIFO holds at least one complete 32-bit word.
REQ-006 fifo_empty  in  1  FIFO holds no data.
REQ-007 fifo_rd_data  in  DATA_W  FIFO read data, valid in the same cycle as fifo_rd.
REQ-008 fifo_flush_done  in  1  FIFO flush complete.
REQ-009 fifo_rd  out  1  read strobe to the FIFO.
REQ-010 fifo_flush_req  out  1  flush request to the FIFO.
REQ-011 flush_cmd  in  1  single-cycle software flush pulse.
REQ-012 m_valid / m_ready / m_data  out/in/out  1/1/DATA_W  downstream valid-ready stream.
REQ-013 flush_cmpl  out  1  one-cycle pulse once all flush words have left m_data.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states: IDLE, RUN, FLUSH, CMPL; encoding held in the package.
REQ-016 IDLE->RUN when fifo_vld_rd_data=1; RUN->IDLE when fifo_vld_rd_data=0 and the buffer is empty.
REQ-017 From IDLE or RUN, go to FLUSH on a flush trigger (flush_cmd=1, or timeout per REQ-029) while fifo_empty=0; flush_cmd while fifo_empty=1 is ignored.
REQ-018 flush_cmd while in FLUSH or CMPL is ignored; no pending flag is kept.
REQ-019 fifo_flush_req is a registered output: 1 in FLUSH, and 0 in all other states.
REQ-020 FLUSH->CMPL in the cycle after fifo_flush_done=1 is sampled; fifo_flush_req deasserts in that same transition.
REQ-021 CMPL->IDLE when the output buffer is empty; flush_cmpl pulses exactly one cycle on that transition.
REQ-022 Output buffer: 2-entry in-order buffer; space = (count - pop) < 2, where pop = m_valid & m_ready.
REQ-023 fifo_rd = space & (state RUN & fifo_vld_rd_data, or state FLUSH & !fifo_empty); fifo_rd is combinational and never asserts in IDLE or CMPL.
REQ-024 fifo_rd_data is captured on the fifo_rd cycle; m_valid rises the next cycle (1-cycle latency); zero-padded flush words pass through unmodified.
REQ-025 m_data stays stable while m_valid=1 and m_ready=0; no word is dropped or duplicated.
REQ-026 A simultaneous push and pop with count=2 is legal (count stays 2); a simultaneous push and pop with count=0 is not possible.
REQ-027 FIFO words written after fifo_flush_req rises are read in RUN after CMPL/IDLE, never counted toward the flush.

Reset
REQ-028 On rst=0: state=IDLE, buffer count=0, timeout counter=0; fifo_rd, fifo_flush_req, m_valid, flush_cmpl and busy are 0, and m_data is 0. Reset mid-flush aborts the flush immediately and discards buffered words.

Configuration
REQ-029 Macro FIFO_RD_DRAIN_AUTO_FLUSH_EN: when defined, an 8-bit counter increments each cycle in IDLE with fifo_empty=0 and fifo_vld_rd_data=0; it clears on any other condition; reaching TIMEOUT-1 is a flush trigger.
REQ-030 When the macro is undefined, there is no counter logic, and flush_cmd is the only flush trigger.

Structure
REQ-031 Package fifo_rd_drain_pkg holds the state enum typedef, DATA_W_DEF=32 and TIMEOUT_DEF=16.
REQ-032 Sub-module drain_skid_buf implements the 2-entry output buffer (push, din, pop, dout, count).

Verification
REQ-033 Eight 4-bit writes 0x1..0x8 upstream, m_ready=1 -> one fifo_rd, m_data=0x87654321 one cycle later, busy returns 0.
REQ-034 Three words ready, m_ready=0 for 5 cycles -> exactly 2 fifo_rd strobes, m_data held; after release, three words arrive in order.
REQ-035 Nibbles 0xA,0xB only, then a flush_cmd pulse -> fifo_flush_req stays high until fifo_flush_done; m_data=0x000000BA; flush_cmpl pulses once.
REQ-036 Flush in progress, new nibbles written -> those nibbles are absent from the flush words and delivered only after flush_cmpl.
REQ-037 With FIFO_RD_DRAIN_AUTO_FLUSH_EN defined and one nibble stalled for 16 cycles -> fifo_flush_req rises; with the macro undefined, no flush occurs.
REQ-038 rst asserted while in FLUSH -> all outputs 0 asynchronously; after release, state is IDLE and no flush_cmpl pulse occurs.
